// File: rtl/irq_seq.sv
// Prioritised interrupt sequencer: edge/level pending latches, mask + global enable, IDLE/ENTER/SERVICE handshake.
// Latency: input edge -> pending +1 cycle -> irq_take +2 cycles; no backpressure, late requests wait pending until return.
module irq_seq #(
  parameter int N_IRQ = 4,
  parameter int VEC_W = 3,
  parameter int EDGE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_din,
  input  logic             gie_we,
  input  logic             gie_din,
  input  logic             ret_i,
  output logic             irq_take,
  output logic [VEC_W-1:0] vec_sel,
  output logic             in_service,
  output logic [VEC_W-1:0] isr_id,
  output logic [N_IRQ-1:0] pending
);

  typedef enum logic [1:0] {S_IDLE, S_ENTER, S_SERVICE} state_t;

  state_t           r_state;
  logic [VEC_W-1:0] r_id;
  logic [N_IRQ-1:0] r_prev;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_mask;
  logic             r_gie;
  logic             r_armed;
  logic             r_irq_take;
  logic [VEC_W-1:0] r_vec_sel;
  logic             r_in_service;
  logic [VEC_W-1:0] r_isr_id;

  logic [N_IRQ-1:0] w_cand;
  logic [N_IRQ-1:0] w_set;
  logic [N_IRQ-1:0] w_clr;
  logic [N_IRQ-1:0] w_pend_nxt;
  logic             w_win_vld;
  logic [VEC_W-1:0] w_win_id;

  always_comb begin
    w_cand    = r_pending & r_mask & {N_IRQ{r_gie}};
    w_win_vld = |w_cand;
    w_win_id  = '0;
    // Descending scan so the lowest set index is the last (winning) assignment.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_cand[i]) w_win_id = VEC_W'(i);
    end
    // r_armed masks the first cycle after reset so lines already high are not seen as edges.
    w_set = irq_in & ~r_prev & {N_IRQ{r_armed}};
    w_clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      w_clr[i] = (r_state == S_ENTER) && (r_id == VEC_W'(i));
    end
    w_pend_nxt = (EDGE != 0) ? ((r_pending & ~w_clr) | w_set) : irq_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev    <= '0;
      r_armed   <= 1'b0;
      r_pending <= '0;
      r_mask    <= '1;
      r_gie     <= 1'b0;
    end else begin
      r_prev    <= irq_in;
      r_armed   <= 1'b1;
      r_pending <= w_pend_nxt;
      if (mask_we) r_mask <= mask_din;
      if (gie_we)  r_gie  <= gie_din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_id         <= '0;
      r_irq_take   <= 1'b0;
      r_vec_sel    <= '0;
      r_in_service <= 1'b0;
      r_isr_id     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_vld) begin
            r_id       <= w_win_id;
            r_state    <= S_ENTER;
            r_irq_take <= 1'b1;
            r_vec_sel  <= w_win_id + VEC_W'(1);
          end
        end
        S_ENTER: begin
          r_state      <= S_SERVICE;
          r_irq_take   <= 1'b0;
          r_vec_sel    <= '0;
          r_in_service <= 1'b1;
          r_isr_id     <= r_id;
        end
        S_SERVICE: begin
          if (ret_i) begin
            r_state      <= S_IDLE;
            r_in_service <= 1'b0;
            r_isr_id     <= '0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_irq_take   <= 1'b0;
          r_vec_sel    <= '0;
          r_in_service <= 1'b0;
          r_isr_id     <= '0;
        end
      endcase
    end
  end

  assign irq_take   = r_irq_take;
  assign vec_sel    = r_vec_sel;
  assign in_service = r_in_service;
  assign isr_id     = r_isr_id;
  assign pending    = r_pending;

endmodule

// File: tb/tb_irq_seq.sv
// Bench for irq_seq: edge-mode instance checked every cycle against a handler-level model, plus a level-mode instance.
module tb_irq_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] irq_in = 4'b0, mask_din = 4'b0;
  logic       mask_we = 1'b0, gie_we = 1'b0, gie_din = 1'b0, ret_i = 1'b0;
  logic       irq_take, in_service;
  logic [2:0] vec_sel, isr_id;
  logic [3:0] pending;

  logic [3:0] l_irq_in = 4'b0, l_mask_din = 4'b0;
  logic       l_mask_we = 1'b0, l_gie_we = 1'b0, l_gie_din = 1'b0, l_ret_i = 1'b0;
  logic       l_irq_take, l_in_service;
  logic [2:0] l_vec_sel, l_isr_id;
  logic [3:0] l_pending;

  int n_cmp = 0;
  int n_err = 0;

  // Model: which handler is active (-1 none) and how many cycles since it was entered.
  logic [3:0] m_prev, m_pend, m_mask;
  logic       m_armed, m_gie;
  int         m_cur, m_age;

  irq_seq #(.N_IRQ(4), .VEC_W(3), .EDGE(1)) u_dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we), .mask_din(mask_din),
    .gie_we(gie_we), .gie_din(gie_din), .ret_i(ret_i), .irq_take(irq_take),
    .vec_sel(vec_sel), .in_service(in_service), .isr_id(isr_id), .pending(pending)
  );

  irq_seq #(.N_IRQ(4), .VEC_W(3), .EDGE(0)) u_lvl (
    .clk(clk), .reset(reset), .irq_in(l_irq_in), .mask_we(l_mask_we), .mask_din(l_mask_din),
    .gie_we(l_gie_we), .gie_din(l_gie_din), .ret_i(l_ret_i), .irq_take(l_irq_take),
    .vec_sel(l_vec_sel), .in_service(l_in_service), .isr_id(l_isr_id), .pending(l_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev  = 4'b0;
    m_pend  = 4'b0;
    m_mask  = 4'hF;
    m_armed = 1'b0;
    m_gie   = 1'b0;
    m_cur   = -1;
    m_age   = 0;
  endtask

  task automatic tick();
    logic [3:0] s_in, s_md, s_lin, cand, clr, rise;
    logic       s_rst, s_mwe, s_gwe, s_gd, s_ret;
    int         nxt;
    s_in = irq_in; s_md = mask_din; s_lin = l_irq_in; s_rst = reset;
    s_mwe = mask_we; s_gwe = gie_we; s_gd = gie_din; s_ret = ret_i;
    @(posedge clk);
    if (!s_rst) begin
      model_reset();
    end else begin
      cand = m_pend & m_mask & {4{m_gie}};
      clr  = 4'b0;
      rise = s_in & ~m_prev & {4{m_armed}};
      if (m_cur < 0) begin
        nxt = -1;
        for (int i = 0; i < 4; i++) if (cand[i] && nxt < 0) nxt = i;
        m_cur = nxt;
        m_age = 0;
      end else if (m_age == 0) begin
        clr[m_cur] = 1'b1;
        m_age = 1;
      end else if (s_ret) begin
        m_cur = -1;
      end
      m_pend  = (m_pend & ~clr) | rise;
      m_prev  = s_in;
      m_armed = 1'b1;
      if (s_mwe) m_mask = s_md;
      if (s_gwe) m_gie = s_gd;
    end
    #1;
    chk("take", irq_take, (m_cur >= 0 && m_age == 0));
    chk("vec_sel", vec_sel, (m_cur >= 0 && m_age == 0) ? m_cur + 1 : 0);
    chk("in_service", in_service, (m_cur >= 0 && m_age > 0));
    chk("isr_id", isr_id, (m_cur >= 0 && m_age > 0) ? m_cur : 0);
    chk("pending", pending, m_pend);
    chk("lvl_pending", l_pending, s_rst ? s_lin : 4'b0);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    model_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_take", irq_take, 0);
    chk("rst_vec", vec_sel, 0);
    chk("rst_insv", in_service, 0);
    chk("rst_isr", isr_id, 0);
    chk("rst_pend", pending, 0);
    ticks(2);
    reset = 1'b1;
    gie_we = 1'b1; gie_din = 1'b1; tick(); gie_we = 1'b0;

    // Basic entry on channel 2
    irq_in = 4'b0100; tick(); chk("basic_pend", pending, 4'b0100);
    irq_in = 4'b0; tick(); chk("basic_take", irq_take, 1); chk("basic_vec", vec_sel, 3);
    tick(); chk("basic_insv", in_service, 1); chk("basic_isr", isr_id, 2);
    ticks(3); chk("basic_hold", isr_id, 2);
    ret_i = 1'b1; tick(); ret_i = 1'b0; chk("basic_ret", in_service, 0);
    ticks(2);

    // Priority: channels 1 and 3 together
    irq_in = 4'b1010; tick(); irq_in = 4'b0; chk("prio_pend", pending, 4'b1010);
    tick(); chk("prio1_take", irq_take, 1); chk("prio1_vec", vec_sel, 2);
    tick(); chk("prio1_isr", isr_id, 1); chk("prio1_pend", pending, 4'b1000);
    ret_i = 1'b1; tick(); ret_i = 1'b0; chk("prio_gap", irq_take, 0);
    tick(); chk("prio2_take", irq_take, 1); chk("prio2_vec", vec_sel, 4);
    tick(); ret_i = 1'b1; tick(); ret_i = 1'b0; chk("prio_end_pend", pending, 0);
    tick();

    // Masking keeps the pending bit until the channel is re-enabled
    mask_we = 1'b1; mask_din = 4'b1110; tick(); mask_we = 1'b0;
    irq_in = 4'b0001; tick(); irq_in = 4'b0; ticks(3);
    chk("mask_take", irq_take, 0); chk("mask_pend", pending, 4'b0001);
    mask_we = 1'b1; mask_din = 4'hF; tick(); mask_we = 1'b0; chk("mask_wait", irq_take, 0);
    tick(); chk("mask_take2", irq_take, 1); chk("mask_vec", vec_sel, 1);
    tick(); ret_i = 1'b1; tick(); ret_i = 1'b0; tick();

    // No nesting: channel 0 arrives while channel 3 is in service
    irq_in = 4'b1000; tick(); irq_in = 4'b0; tick(); chk("nest_vec3", vec_sel, 4); tick();
    irq_in = 4'b0001; tick(); irq_in = 4'b0; chk("nest_pend", pending, 4'b0001);
    ticks(3); chk("nest_none", irq_take, 0); chk("nest_isr", isr_id, 3);
    ret_i = 1'b1; tick(); ret_i = 1'b0; chk("nest_r1", irq_take, 0);
    tick(); chk("nest_r2_take", irq_take, 1); chk("nest_r2_vec", vec_sel, 1);
    tick(); ret_i = 1'b1; tick(); ret_i = 1'b0; tick();

    // New edge during ENTER of the same channel survives the clear; gie=0 does not abort service
    irq_in = 4'b0100; tick(); irq_in = 4'b0; tick(); chk("setwin_take", irq_take, 1);
    irq_in = 4'b0100; tick(); irq_in = 4'b0; chk("setwin_pend", pending, 4'b0100);
    gie_we = 1'b1; gie_din = 1'b0; tick(); gie_we = 1'b0; chk("gie_insv", in_service, 1);
    ticks(2); ret_i = 1'b1; tick(); ret_i = 1'b0; ticks(3);
    chk("gie_off_take", irq_take, 0); chk("gie_off_insv", in_service, 0);
    chk("gie_off_pend", pending, 4'b0100);
    gie_we = 1'b1; gie_din = 1'b1; tick(); gie_we = 1'b0;
    tick(); chk("regrant_take", irq_take, 1); chk("regrant_vec", vec_sel, 3);
    tick(); ret_i = 1'b1; tick(); ret_i = 1'b0; tick();

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      irq_in   = 4'($urandom & $urandom);
      ret_i    = ($urandom_range(0, 3) == 0);
      mask_we  = ($urandom_range(0, 15) == 0);
      mask_din = 4'($urandom);
      gie_we   = ($urandom_range(0, 15) == 0);
      gie_din  = ($urandom_range(0, 3) != 0);
      tick();
    end
    irq_in = 4'b0; ret_i = 1'b0; mask_we = 1'b0; gie_we = 1'b0;

    // Reset in the middle of a handler, lines held high across release
    reset = 1'b0; tick(); reset = 1'b1;
    gie_we = 1'b1; gie_din = 1'b1; tick(); gie_we = 1'b0;
    irq_in = 4'b0010; tick(); irq_in = 4'b0; tick(); chk("rs_take", irq_take, 1);
    ticks(2); chk("rs_insv", in_service, 1);
    reset = 1'b0; #1;
    chk("rs_now_take", irq_take, 0);
    chk("rs_now_vec", vec_sel, 0);
    chk("rs_now_insv", in_service, 0);
    chk("rs_now_isr", isr_id, 0);
    chk("rs_now_pend", pending, 0);
    model_reset();
    irq_in = 4'hF; ticks(2); reset = 1'b1; ticks(3);
    chk("rs_nopend", pending, 0);
    gie_we = 1'b1; gie_din = 1'b1; tick(); gie_we = 1'b0; ticks(3);
    chk("rs_notake", irq_take, 0); chk("rs_nopend2", pending, 0);
    irq_in = 4'b0; tick();

    // Level mode: a level still high after return re-enters
    l_gie_we = 1'b1; l_gie_din = 1'b1; tick(); l_gie_we = 1'b0;
    l_irq_in = 4'b0010; tick(); chk("lv_pend", l_pending, 4'b0010);
    tick(); chk("lv_take", l_irq_take, 1); chk("lv_vec", l_vec_sel, 2);
    tick(); chk("lv_insv", l_in_service, 1); chk("lv_isr", l_isr_id, 1);
    tick();
    l_ret_i = 1'b1; tick(); l_ret_i = 1'b0; chk("lv_r1", l_irq_take, 0);
    tick(); chk("lv_r2_take", l_irq_take, 1); chk("lv_r2_vec", l_vec_sel, 2);
    l_irq_in = 4'b0; ticks(2);
    l_ret_i = 1'b1; tick(); l_ret_i = 1'b0; ticks(3);
    chk("lv_done_take", l_irq_take, 0); chk("lv_done_insv", l_in_service, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irq_seq.md
IRQ_SEQ -- requirements
Module: irq_seq

Interface
REQ-001 Parameter N_IRQ, default 4: number of interrupt channels, range 1..15.
REQ-002 Parameter VEC_W, default 3: vector width; SHALL satisfy 2**VEC_W > N_IRQ.
REQ-003 Parameter EDGE, default 1: 1 = rising-edge-triggered channels, 0 = level-triggered channels.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 irq_in  input  N_IRQ  interrupt request lines; bit 0 has highest priority.
REQ-007 mask_we  input  1  write strobe for the mask register.
REQ-008 mask_din  input  N_IRQ  new mask value; 1 = channel enabled.
REQ-009 gie_we  input  1  write strobe for the global interrupt enable.
REQ-010 gie_din  input  1  new global enable value.
REQ-011 ret_i  input  1  one-cycle return-from-interrupt strobe, decoded by the control unit.
REQ-012 irq_take  output  1  one-cycle request to the control unit: push PC, no increment, no register or memory writes.
REQ-013 vec_sel  output  VEC_W  PC source select: 0 = normal; id+1 = vector of channel id.
REQ-014 in_service  output  1  handler active.
REQ-015 isr_id  output  VEC_W  index of the channel in service; 0 when idle.
REQ-016 pending  output  N_IRQ  current pending latches, readable for debug and I/O.

Function
REQ-017 EDGE=1: irq_in SHALL be registered into prev; pending[i] SHALL set on the cycle after irq_in[i]=1 and prev[i]=0.
REQ-018 EDGE=0: pending[i] SHALL equal irq_in[i] registered one cycle.
REQ-019 Candidate set SHALL be pending & mask & {N_IRQ{gie}}; the winner SHALL be the lowest-index set bit.
REQ-020 FSM states SHALL be IDLE, ENTER and SERVICE, with registered outputs only.
REQ-021 IDLE: a non-empty candidate set SHALL latch the winner into id and move to ENTER on the next edge; otherwise the FSM stays in IDLE.
REQ-022 ENTER: the FSM SHALL last exactly one cycle with irq_take=1 and vec_sel=id+1; pending[id] SHALL clear in EDGE=1 mode; next state SERVICE.
REQ-023 SERVICE: in_service=1, isr_id=id, irq_take=0, vec_sel=0; ret_i=1 SHALL move the FSM to IDLE.
REQ-024 Latency: a rising edge of irq_in at cycle n SHALL give pending=1 at n+1, state ENTER at n+2, and irq_take=1 during cycle n+2.
REQ-025 No nesting: irqs arriving in ENTER or SERVICE SHALL only set pending and SHALL be arbitrated in IDLE after return.
REQ-026 After ret_i the FSM SHALL stay in IDLE for at least one cycle before the next ENTER.
REQ-027 ret_i SHALL be ignored in IDLE and ENTER.
REQ-028 Simultaneous set and clear on the same channel in ENTER: set SHALL win and the channel stays pending.
REQ-029 mask_we and gie_we SHALL take effect at the next edge; masked channels SHALL keep their pending bit and be serviced when unmasked.
REQ-030 Writing gie=0 during SERVICE SHALL NOT abort the current handler.
REQ-031 EDGE=0: a level still high after return SHALL re-enter; clearing the source is the handler's duty.

Reset
REQ-032 reset=0 SHALL force immediately, regardless of clk: state IDLE, id=0, prev=0, pending=0, mask all ones, gie=0, irq_take=0, vec_sel=0, in_service=0, isr_id=0.
REQ-033 Reset asserted mid-ENTER or mid-SERVICE SHALL abandon the handler with no further irq_take.
REQ-034 Edges present during reset SHALL NOT be latched: prev SHALL load irq_in on the first edge after release, so no pending is set for lines already high.

Verification (N_IRQ=4, EDGE=1)
REQ-035 Basic entry: gie=1; pulse irq_in=4'b0100 at cycle n -> irq_take=1 and vec_sel=3 at n+2, then in_service=1 and isr_id=2 until ret_i.
REQ-036 Priority: irq_in=4'b1010 in one cycle -> first ENTER has vec_sel=2; after ret_i, second ENTER has vec_sel=4; pending=0 at the end.
REQ-037 Masking: mask_din=4'b1110 written; pulse irq_in[0] -> no irq_take and pending=4'b0001; write mask=4'b1111 -> ENTER with vec_sel=1.
REQ-038 No nesting: pulse irq_in[0] during a channel-3 SERVICE -> no irq_take until ret_i; channel-0 ENTER follows no earlier than 2 cycles after ret_i.
REQ-039 Reset mid-service: reset low during SERVICE -> all outputs 0 immediately; irq_in held high across release -> no pending and no irq_take.
REQ-040 Level mode (EDGE=0): irq_in[1] held high across ret_i -> second ENTER with vec_sel=2.
